// File: rtl/park_pkg.sv
// Shared types for the parking-lot controller: lane FSM states and {a,b} sensor codes.
package park_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_BA = 3'd5,
    OUT_A  = 3'd6,
    FAULT  = 3'd7
  } lane_state_t;

  localparam logic [1:0] CODE_CLR = 2'b00;
  localparam logic [1:0] CODE_A   = 2'b10;
  localparam logic [1:0] CODE_B   = 2'b01;
  localparam logic [1:0] CODE_AB  = 2'b11;

  // Per-cycle pulse popcount width; covers up to 8 lanes.
  localparam int unsigned POP_W = 4;

endpackage

// File: rtl/park_lane_fsm.sv
// One gate lane: optional sensor debounce (PARK_DEBOUNCE_EN), direction FSM,
// registered entry/exit pulses and a sticky fault flag.
module park_lane_fsm
  import park_pkg::*;
`ifdef PARK_DEBOUNCE_EN
#(
  parameter int unsigned DEB_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic lane_fault
);

  logic [1:0] raw;
  logic [1:0] code;

  assign raw = {a, b};

`ifdef PARK_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       filt;
  logic [DEB_W-1:0] deb_cnt [2];

  // Filtered bit follows raw only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt       <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          filt[i]    <= raw[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign code = filt;
`else
  assign code = raw;
`endif

  lane_state_t state, state_nxt;
  logic        entry_c, exit_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      lane_fault  <= 1'b0;
    end else begin
      state       <= state_nxt;
      entry_pulse <= entry_c;
      exit_pulse  <= exit_c;
      lane_fault  <= lane_fault | (state_nxt == FAULT);
    end
  end

  // OUT_* states mirror IN_* with the beams swapped.
  always_comb begin
    state_nxt = state;
    entry_c   = 1'b0;
    exit_c    = 1'b0;
    case (state)
      IDLE: begin
        case (code)
          CODE_A:  state_nxt = IN_A;
          CODE_B:  state_nxt = OUT_B;
          CODE_AB: state_nxt = FAULT;
          default: state_nxt = IDLE;
        endcase
      end
      IN_A: begin
        case (code)
          CODE_AB:  state_nxt = IN_AB;
          CODE_CLR: state_nxt = IDLE;
          CODE_B:   state_nxt = FAULT;
          default:  state_nxt = IN_A;
        endcase
      end
      IN_AB: begin
        case (code)
          CODE_B:   state_nxt = IN_B;
          CODE_A:   state_nxt = IN_A;
          CODE_CLR: state_nxt = FAULT;
          default:  state_nxt = IN_AB;
        endcase
      end
      IN_B: begin
        case (code)
          CODE_CLR: begin
            state_nxt = IDLE;
            entry_c   = 1'b1;
          end
          CODE_AB: state_nxt = IN_AB;
          CODE_A:  state_nxt = FAULT;
          default: state_nxt = IN_B;
        endcase
      end
      OUT_B: begin
        case (code)
          CODE_AB:  state_nxt = OUT_BA;
          CODE_CLR: state_nxt = IDLE;
          CODE_A:   state_nxt = FAULT;
          default:  state_nxt = OUT_B;
        endcase
      end
      OUT_BA: begin
        case (code)
          CODE_A:   state_nxt = OUT_A;
          CODE_B:   state_nxt = OUT_B;
          CODE_CLR: state_nxt = FAULT;
          default:  state_nxt = OUT_BA;
        endcase
      end
      OUT_A: begin
        case (code)
          CODE_CLR: begin
            state_nxt = IDLE;
            exit_c    = 1'b1;
          end
          CODE_AB: state_nxt = OUT_BA;
          CODE_B:  state_nxt = FAULT;
          default: state_nxt = OUT_A;
        endcase
      end
      FAULT: begin
        if (code == CODE_CLR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/park_lot_ctrl.sv
// Parking-lot controller top: per-lane direction FSMs plus a saturating shared
// occupancy counter. PARK_DEBOUNCE_EN enables per-beam debounce in each lane.
module park_lot_ctrl
  import park_pkg::*;
#(
  parameter int unsigned N_LANES  = 2,
  parameter int unsigned CAPACITY = 15,
`ifdef PARK_DEBOUNCE_EN
  parameter int unsigned DEB_CYCLES = 4,
`endif
  localparam int unsigned CNT_W = $clog2(CAPACITY + 1)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LANES-1:0] sens_a,
  input  logic [N_LANES-1:0] sens_b,
  output logic [N_LANES-1:0] entry_pulse,
  output logic [N_LANES-1:0] exit_pulse,
  output logic [N_LANES-1:0] lane_fault,
  output logic [N_LANES-1:0] gate_allow,
  output logic [CNT_W-1:0]   count,
  output logic [CNT_W-1:0]   free_slots,
  output logic               full,
  output logic               empty,
  output logic               ovf_flag,
  output logic               unf_flag
);

  localparam int unsigned SUM_W = CNT_W + 4;

  for (genvar g = 0; g < int'(N_LANES); g++) begin : g_lane
    park_lane_fsm
`ifdef PARK_DEBOUNCE_EN
      #(.DEB_CYCLES(DEB_CYCLES))
`endif
      u_lane (
        .clk         (clk),
        .rst         (rst),
        .a           (sens_a[g]),
        .b           (sens_b[g]),
        .entry_pulse (entry_pulse[g]),
        .exit_pulse  (exit_pulse[g]),
        .lane_fault  (lane_fault[g])
      );
  end

  logic [POP_W-1:0]        e_cnt;
  logic [POP_W-1:0]        x_cnt;
  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      e_cnt = e_cnt + POP_W'(entry_pulse[i]);
      x_cnt = x_cnt + POP_W'(exit_pulse[i]);
    end
  end

  // Wide signed sum lets same-cycle entries and exits net out before clamping.
  always_comb begin
    sum_c = signed'(SUM_W'(count)) + signed'(SUM_W'(e_cnt)) - signed'(SUM_W'(x_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else if (sum_c > signed'(SUM_W'(CAPACITY))) begin
      count    <= CNT_W'(CAPACITY);
      ovf_flag <= 1'b1;
    end else if (sum_c[SUM_W-1]) begin
      count    <= '0;
      unf_flag <= 1'b1;
    end else begin
      count    <= CNT_W'(sum_c);
    end
  end

  assign full       = (count == CNT_W'(CAPACITY));
  assign empty      = (count == '0);
  assign free_slots = CNT_W'(CAPACITY) - count;
  assign gate_allow = {N_LANES{~full}};

endmodule

// File: doc/park_lot_ctrl.md
Name: park_lot_ctrl

Overview:
- Next-generation parking-lot controller: N_LANES independent gate lanes, each with a two-beam sensor pair (a = outer beam, b = inner beam).
- Each lane runs a direction FSM that emits a one-cycle entry or exit pulse only for a complete, non-reversed traversal.
- A shared occupancy counter sums all lanes per cycle. It is bounded by CAPACITY and drives full/empty/free flags and per-lane gate permission.
- Sits between the raw gate sensors and the lot display/barrier logic.

Parameters:
- N_LANES, 2, number of gate lanes (1..8)
- CAPACITY, 15, maximum occupancy (1..1023)
- CNT_W, $clog2(CAPACITY+1), occupancy width (derived; do not override)
- DEB_CYCLES, 4, debounce stable-sample count (used only with the optional feature)

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst  in  1  synchronous active-high reset.
- sens_a  in  N_LANES  outer beam per lane; 1 = blocked.
- sens_b  in  N_LANES  inner beam per lane; 1 = blocked.
- entry_pulse  out  N_LANES  one-cycle pulse per completed entry.
- exit_pulse  out  N_LANES  one-cycle pulse per completed exit.
- lane_fault  out  N_LANES  sticky; set on an illegal sensor jump.
- gate_allow  out  N_LANES  entry barrier may open; equals ~full for all lanes.
- count  out  CNT_W  current occupancy.
- free_slots  out  CNT_W  CAPACITY - count.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- ovf_flag  out  1  sticky; an entry was dropped at capacity.
- unf_flag  out  1  sticky; an exit was dropped at zero.

Behaviour:
- Reset, synchronous, while rst=1 at posedge:
  - All lane FSMs go to IDLE.
  - Pulses, faults, ovf/unf are 0; count is 0; empty=1; full=0; free_slots=CAPACITY; gate_allow all 1.
  - Reset asserted mid-traversal abandons the traversal; no pulse is emitted.
- Lane FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, FAULT. Sensor code is {a,b}.
  - IDLE: 10 goes to IN_A; 01 goes to OUT_B; 11 goes to FAULT; 00 stays.
  - IN_A: 11 goes to IN_AB; 00 goes to IDLE (backed out); 10 stays; 01 goes to FAULT.
  - IN_AB: 01 goes to IN_B; 10 goes to IN_A; 11 stays; 00 goes to FAULT.
  - IN_B: 00 goes to IDLE and asserts entry_pulse; 11 goes to IN_AB; 01 stays; 10 goes to FAULT.
  - OUT_B, OUT_BA, OUT_A mirror the IN_ states with a and b swapped. OUT_A with 00 goes to IDLE and asserts exit_pulse.
  - FAULT: sets lane_fault (sticky until rst). Stays in FAULT until 00 is sampled, then goes to IDLE. No pulse is emitted.
- Pulse timing: the pulse is registered and high for exactly the cycle following the edge that sampled the completing 00. Consecutive traversals produce separate pulses.
- Counter:
  - Per cycle, E = popcount(entry_pulse) and X = popcount(exit_pulse).
  - The update applies at the edge after the pulses, so count lags the completing sensor sample by 2 edges.
  - Computation uses CNT_W+4 bit signed arithmetic: next = count + E - X.
  - If next > CAPACITY: count = CAPACITY and ovf_flag is set.
  - If next < 0: count = 0 and unf_flag is set.
  - Simultaneous entry and exit on different lanes net out. Example: count=CAPACITY with E=1, X=1 keeps count=CAPACITY and does not set ovf.
- Flags: full, empty, free_slots and gate_allow are combinational from the count register.
- Lane FSMs do not depend on full. An entry traversal already in progress still completes and is counted, subject to saturation.

Optional Feature:
- PARK_DEBOUNCE_EN defined:
  - Each sensor bit passes through a counter filter. The filtered value changes only after DEB_CYCLES consecutive identical raw samples.
  - This adds DEB_CYCLES cycles of latency. Glitches shorter than DEB_CYCLES are ignored.
  - Filter state resets to 0 (unblocked).
- PARK_DEBOUNCE_EN undefined: the FSMs sample raw inputs directly; DEB_CYCLES is unused.

Decomposition:
- Package park_pkg: lane_state_t enum (8 states, 3-bit encoding) and the sensor-code localparams (CODE_CLR=00, CODE_A=10, CODE_B=01, CODE_AB=11).
- Sub-module park_lane_fsm: one lane, containing the optional debounce, FSM, pulse registers and fault flag. Instantiated N_LANES times via generate.
- The top level holds the popcount, saturating counter and flags.

Test Plan (N_LANES=2, CAPACITY=3, no debounce unless stated):
- Lane0 sequence 00,10,11,01,00 -> entry_pulse[0]=1 for one cycle; count goes 0 to 1 one edge later; empty drops to 0.
- Lane0 sequence 10,11,10,00 (back-out) -> no pulse; count unchanged.
- Fill to 3, then a 4th entry on lane1 -> count stays 3; full=1; gate_allow=00; ovf_flag=1.
- With count=3, entry on lane0 and exit on lane1 in the same cycle -> count stays 3; ovf stays 0.
- Exit at count=0 -> count 0, unf_flag=1. Lane0 00 to 11 -> lane_fault[0]=1; lane returns to IDLE only after 00.
- PARK_DEBOUNCE_EN with DEB_CYCLES=4: a 3-cycle glitch on a is ignored. A full entry sequence with 5-cycle phases gives an entry pulse 4 cycles later than in the non-debounced case.
